// File: rtl/lsu_sequencer.sv
// lsu_sequencer
//   Multi-cycle load/store sequencer between the pipeline memory stage and a
//   single-port, synchronous-read data RAM. One request at a time. Loads get
//   byte/halfword lane extraction with sign/zero extension. Sub-word stores
//   are done as read-modify-write, so the RAM needs no byte enables.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   : misaligned halfword/word accesses are rejected (rsp_err_o)
//     undefined : misaligned low address bits are forced to alignment
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   req_valid_i / req_ready_o    request handshake (ready == sequencer idle)
//   req_we_i, req_funct3_i       store flag, access size/sign (b,h,w,bu,hu)
//   req_addr_i, req_wdata_i      byte address, right-aligned store data
//   mem_en_o, mem_we_o           RAM access / write strobes (registered)
//   mem_addr_o, mem_wdata_o      RAM word address / full write word
//   mem_rdata_i                  RAM read data, valid the cycle after a read
//   rsp_valid_o                  one-cycle completion pulse
//   rsp_rdata_o, rsp_err_o       extended load data / request rejected
module lsu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_AW     = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RSP  = 3'd4;

  // Lane extraction with sign/zero extension (32-bit data only).
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/halfword lane of the read word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = w;
    case (f3)
      3'b000: r[{off, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = w;
    endcase
    return r;
  endfunction

  // Request rejection: bad funct3, sign-less stores, and optionally misalignment.
  function automatic logic req_illegal(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] lo);
    logic bad;
    case (f3)
      3'b000, 3'b001, 3'b010: bad = 1'b0;
      3'b100, 3'b101:         bad = we;
      default:                bad = 1'b1;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'b001 || f3 == 3'b101) && lo[0]) bad = 1'b1;
    else if (f3 == 3'b010 && lo != 2'b00)        bad = 1'b1;
    else                                         bad = bad;
`else
    bad = bad | (1'b0 & lo[0]);
`endif
    return bad;
  endfunction

  logic [2:0]            state_q, state_d;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  mem_en_q, mem_we_q;
  logic [MEM_AW-1:0]     mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  accept_s, illegal_s;
  logic                  unused_addr_s;

  // Address bits above the RAM word address are deliberately dropped.
  assign unused_addr_s = ^req_addr_i[ADDR_WIDTH-1:MEM_AW+2];

  assign accept_s  = req_valid_i & (state_q == S_IDLE);
  assign illegal_s = req_illegal(req_we_i, req_funct3_i, req_addr_i[1:0]);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (illegal_s)                                 state_d = S_RSP;
          else if (req_we_i && req_funct3_i == 3'b010)   state_d = S_WR;
          else                                           state_d = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD:    state_d = S_WAIT;
      S_WAIT:  state_d = we_q ? S_WR : S_RSP;
      S_WR:    state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latches and registered outputs (all updated on state entry).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_s) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        off_q   <= req_addr_i[1:0];
        wdata_q <= req_wdata_i;
      end
      // Word address is only captured for requests that touch the RAM.
      if (accept_s && !illegal_s) mem_addr_q <= req_addr_i[MEM_AW+1:2];
      mem_en_q <= (state_d == S_RD) || (state_d == S_WR);
      mem_we_q <= (state_d == S_WR);
      if (accept_s && state_d == S_WR) begin
        mem_wdata_q <= req_wdata_i;
      end else if (state_q == S_WAIT && state_d == S_WR) begin
        mem_wdata_q <= store_merge(mem_rdata_i, wdata_q, f3_q, off_q);
      end
      rsp_valid_q <= (state_d == S_RSP);
      // Only the direct IDLE->RSP path is an error response.
      rsp_err_q   <= (state_q == S_IDLE) && (state_d == S_RSP);
      if (state_q == S_WAIT && state_d == S_RSP) begin
        rsp_rdata_q <= load_extract(mem_rdata_i, f3_q, off_q);
      end else begin
        rsp_rdata_q <= '0;
      end
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
module tb_lsu_sequencer;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_f3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  lsu_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct3_i(req_f3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read single-port RAM.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference memory and expectations for the request in flight (driver-owned).
  logic [31:0] ref_mem [0:1023];
  int          exp_kind;   // 0 illegal, 1 load, 2 sub-word store, 3 word store
  int          exp_lat;
  logic        exp_err;
  logic [31:0] exp_rd, exp_new, exp_wd;
  logic [9:0]  exp_wa;
  int          req_seq = 0;
  int          tmo_seq = 0;
  int          lit_seq = 0;
  int          lit_what = 0;
  logic [31:0] lit_val = 32'd0;
  logic [9:0]  lit_addr = 10'd0;

  // Compare-process state.
  int          checks = 0;
  int          failures = 0;
  int          done_seq = 0;

  task automatic model(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    int unsigned off, wa, width, sh;
    logic [31:0] w, v, mask;
    logic        illegal;
    wa = (addr / 4) % 1024;
    off = addr % 4;
    w = ref_mem[wa];
    illegal = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (we && f3 >= 3'd4);
    if (TRAP && (f3 == 3'd1 || f3 == 3'd5) && (addr % 2) != 0) illegal = 1'b1;
    if (TRAP && f3 == 3'd2 && off != 0) illegal = 1'b1;
    exp_wa = wa[9:0]; exp_new = w; exp_rd = 32'd0; exp_err = 1'b0; exp_wd = 32'd0;
    if (illegal) begin
      exp_kind = 0; exp_lat = 1; exp_err = 1'b1;
    end else if (!we) begin
      exp_kind = 1; exp_lat = 3;
      if (f3 == 3'd0 || f3 == 3'd4) begin
        v = (w >> (8 * off)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
        v = (w >> (16 * (off / 2))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
        v = w;
      end
      exp_rd = v;
    end else if (f3 == 3'd2) begin
      exp_kind = 3; exp_lat = 2; exp_new = wd; exp_wd = wd;
    end else begin
      exp_kind = 2; exp_lat = 4;
      width = (f3 == 3'd0) ? 8 : 16;
      sh = (f3 == 3'd0) ? 8 * off : 16 * (off / 2);
      mask = ((32'd1 << width) - 32'd1) << sh;
      exp_new = (w & ~mask) | ((wd << sh) & mask);
      exp_wd = exp_new;
    end
  endtask

  // Driver: call at negedge+2; returns at posedge+1 after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); #2; n++; end
    if (!req_ready) tmo_seq++;
    model(we, f3, addr, wd);
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_f3 = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    req_seq++;
  endtask

  task automatic finish_req();
    int n;
    n = 0;
    while (done_seq != req_seq && n < 20) begin @(negedge clk); #2; n++; end
    if (done_seq != req_seq) tmo_seq++;
    else ref_mem[exp_wa] = exp_new;
  endtask

  task automatic req(input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd);
    issue(we, f3, addr, wd);
    finish_req();
  endtask

  // what: 0 DUT last rdata, 1 RAM word, 2 model load data, 3 model new word, 4 DUT last err
  task automatic lit(input int what, input logic [31:0] val, input logic [9:0] a);
    lit_what = what; lit_val = val; lit_addr = a;
    lit_seq++;
    @(negedge clk); #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Single compare process, sampling on the falling edge.
  initial begin
    bit          act;
    int          cyc, seen_seq, lit_seen, tmo_seen;
    logic        e_en, e_we;
    logic [31:0] last_rd;
    logic        last_err;
    act = 1'b0; cyc = 0; seen_seq = 0; lit_seen = 0; tmo_seen = 0;
    last_rd = 32'd0; last_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0; seen_seq = req_seq; done_seq = req_seq;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      end else begin
        if (req_seq != seen_seq) begin act = 1'b1; cyc = 0; seen_seq = req_seq; end
        if (act) begin
          cyc++;
          e_en = (exp_kind == 1 && cyc == 1) || (exp_kind == 2 && (cyc == 1 || cyc == 3)) ||
                 (exp_kind == 3 && cyc == 1);
          e_we = (exp_kind == 2 && cyc == 3) || (exp_kind == 3 && cyc == 1);
          chk("mem_en", {31'd0, mem_en}, {31'd0, e_en});
          chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
          if (e_en) chk("mem_addr", {22'd0, mem_addr}, {22'd0, exp_wa});
          if (e_we) chk("mem_wdata", mem_wdata, exp_wd);
          chk("busy_ready", {31'd0, req_ready}, 32'd0);
          chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, cyc == exp_lat});
          if (cyc == exp_lat) begin
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            chk("ram_word", ram[exp_wa], exp_new);
            last_rd = rsp_rdata; last_err = rsp_err;
            act = 1'b0; done_seq = seen_seq;
          end
        end else begin
          chk("idle_ready", {31'd0, req_ready}, 32'd1);
          chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
          chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
      end
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        case (lit_what)
          0:       chk("lit_rsp_rdata", last_rd, lit_val);
          1:       chk("lit_ram", ram[lit_addr], lit_val);
          2:       chk("lit_model_rdata", exp_rd, lit_val);
          3:       chk("lit_model_word", exp_new, lit_val);
          default: chk("lit_rsp_err", {31'd0, last_err}, lit_val);
        endcase
      end
      if (tmo_seq != tmo_seen) begin
        tmo_seen = tmo_seq;
        chk("req_timeout", 32'd0, 32'd1);
      end
    end
  end

  // Directed stimulus.
  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #2;

    // sw then lw
    req(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    lit(1, 32'hDEAD_BEEF, 10'd4);
    req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    lit(0, 32'hDEAD_BEEF, 10'd0);

    // lb / lbu / lh / lhu lane extraction
    req(1'b1, 3'b010, 32'h0000_0010, 32'h80FF_7F01);
    req(1'b0, 3'b000, 32'h0000_0013, 32'h0);
    lit(2, 32'hFFFF_FF80, 10'd0);
    lit(0, 32'hFFFF_FF80, 10'd0);
    req(1'b0, 3'b100, 32'h0000_0013, 32'h0);
    lit(0, 32'h0000_0080, 10'd0);
    req(1'b0, 3'b001, 32'h0000_0012, 32'h0);
    lit(0, 32'hFFFF_80FF, 10'd0);
    req(1'b0, 3'b101, 32'h0000_0010, 32'h0);
    lit(0, 32'h0000_7F01, 10'd0);

    // sb / sh read-modify-write
    req(1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344);
    req(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00AA);
    lit(3, 32'h1122_AA44, 10'd0);
    lit(1, 32'h1122_AA44, 10'd4);
    req(1'b1, 3'b001, 32'h0000_0012, 32'h1234_BEEF);
    lit(1, 32'hBEEF_AA44, 10'd4);

    // illegal funct3
    req(1'b1, 3'b101, 32'h0000_0010, 32'hFFFF_FFFF);
    lit(4, 32'd1, 10'd0);
    req(1'b0, 3'b011, 32'h0000_0010, 32'h0);
    lit(4, 32'd1, 10'd0);

    // misaligned word load
    req(1'b0, 3'b010, 32'h0000_0012, 32'h0);
    lit(4, {31'd0, TRAP}, 10'd0);
    lit(0, TRAP ? 32'd0 : 32'hBEEF_AA44, 10'd0);

    // word address wraps modulo RAM depth
    req(1'b0, 3'b010, 32'h0000_1010, 32'h0);
    lit(0, 32'hBEEF_AA44, 10'd0);

    // asynchronous reset during an in-flight load (RD cycle)
    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    #1 rst = 1'b1;
    @(negedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #2;

    // reset while an sb sits in WAIT
    req(1'b1, 3'b010, 32'h0000_0020, 32'h5566_7788);
    issue(1'b1, 3'b000, 32'h0000_0021, 32'h0000_0099);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) begin @(negedge clk); #2; end
    lit(1, 32'h5566_7788, 10'd8);
    req(1'b0, 3'b010, 32'h0000_0020, 32'h0);
    lit(0, 32'h5566_7788, 10'd0);

    repeat (2) @(negedge clk);
    #2 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
